// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and default widths for the CPU bring-up run controller.
// Contents: sequencer state encoding and the default instruction-memory,
// register-file and run-counter widths used by the controller and interface.
package cpu_run_ctrl_pkg;

    localparam int unsigned DEF_IMEM_AW = 7;
    localparam int unsigned DEF_RF_AW   = 5;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DUMP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Bus bundle between the run controller, the host stream side and the CPU.
// Groups the program-load stream (ld_*), the IM write port (imem_*), the CPU
// reset/clock-enable controls, the RF debug read port (rf_rd_*) and the
// register dump stream (dump_*).
//   slave  : the controller's view (drives ld_ready, imem_*, cpu_*, rf_rd_addr, dump_*)
//   master : the host/CPU environment's view (drives ld_* data, rf_rd_data, dump_ready)
interface cpu_run_ctrl_if #(
    parameter int unsigned IMEM_AW = cpu_run_ctrl_pkg::DEF_IMEM_AW,
    parameter int unsigned RF_AW   = cpu_run_ctrl_pkg::DEF_RF_AW
);
    logic               ld_valid_i;
    logic [31:0]        ld_data_i;
    logic               ld_last_i;
    logic               ld_ready_o;

    logic               imem_we_o;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [31:0]        imem_wdata_o;

    logic               cpu_rst_n_o;
    logic               cpu_ce_o;

    logic [RF_AW-1:0]   rf_rd_addr_o;
    logic [31:0]        rf_rd_data_i;

    logic               dump_valid_o;
    logic [RF_AW-1:0]   dump_idx_o;
    logic [31:0]        dump_data_o;
    logic               dump_ready_i;

    modport slave (
        input  ld_valid_i, ld_data_i, ld_last_i, rf_rd_data_i, dump_ready_i,
        output ld_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
               cpu_rst_n_o, cpu_ce_o, rf_rd_addr_o,
               dump_valid_o, dump_idx_o, dump_data_o
    );

    modport master (
        output ld_valid_i, ld_data_i, ld_last_i, rf_rd_data_i, dump_ready_i,
        input  ld_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
               cpu_rst_n_o, cpu_ce_o, rf_rd_addr_o,
               dump_valid_o, dump_idx_o, dump_data_o
    );

endinterface

// File: rtl/cpu_run_ctrl_run_cycle_counter.sv
// Loadable down-counter that times the CPU run phase.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   load_i        load load_val_i (takes priority over dec_i)
//   load_val_i    value to load
//   dec_i         decrement by one (saturates at zero)
//   zero_o        count is zero
//   last_o        count is one, i.e. this is the final decrement
module run_cycle_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Bring-up sequencer for the single-cycle CPU: loads a program into IM from a
// valid/ready stream with the CPU in reset, runs the CPU for a fixed number of
// clock-enabled cycles, then freezes it and streams out every RF entry.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   start_i       start request, accepted in IDLE or DONE
//   cycles_i      run length in CPU cycles, latched on an accepted start
//   bus           load stream, IM write port, CPU controls, RF read, dump stream
//   busy_o        high in LOAD, RUN, DUMP
//   done_o        high in DONE
//   load_cnt_o    words written by the most recent load
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_AW = DEF_IMEM_AW,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned RF_AW   = DEF_RF_AW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   cycles_i,
    cpu_run_ctrl_if.slave      bus,
    output logic               busy_o,
    output logic               done_o,
    output logic [IMEM_AW:0]   load_cnt_o
);

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] waddr_q, waddr_d;
    logic [IMEM_AW:0]   load_cnt_q, load_cnt_d;
    logic [RF_AW-1:0]   idx_q, idx_d;

    logic start_ok, ld_fire, load_end, dump_fire, dump_end;
    logic run_zero, run_last;

    assign start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign ld_fire   = (state_q == ST_LOAD) && bus.ld_valid_i;
    // A full memory ends the load even without ld_last_i.
    assign load_end  = ld_fire && (bus.ld_last_i || (waddr_q == '1));
    assign dump_fire = (state_q == ST_DUMP) && bus.dump_ready_i;
    assign dump_end  = dump_fire && (idx_q == '1);

    // Loaded on start so the zero flag already answers "skip RUN?" at load end.
    run_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (start_ok),
        .load_val_i (cycles_i),
        .dec_i      (state_q == ST_RUN),
        .zero_o     (run_zero),
        .last_o     (run_last)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_ok) state_d = ST_LOAD;
            ST_LOAD:          if (load_end) state_d = run_zero ? ST_DUMP : ST_RUN;
            ST_RUN:           if (run_last) state_d = ST_DUMP;
            ST_DUMP:          if (dump_end) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Load address, load count and dump index
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            waddr_q    <= '0;
            load_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            waddr_q    <= waddr_d;
            load_cnt_q <= load_cnt_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        waddr_d    = waddr_q;
        load_cnt_d = load_cnt_q;
        idx_d      = idx_q;
        if (start_ok) begin
            waddr_d    = '0;
            load_cnt_d = '0;
            idx_d      = '0;
        end
        if (ld_fire) begin
            waddr_d    = waddr_q + 1'b1;
            load_cnt_d = load_cnt_q + 1'b1;
        end
        if (dump_fire) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Output logic
    always_comb begin
        bus.ld_ready_o   = 1'b0;
        bus.imem_we_o    = 1'b0;
        bus.cpu_rst_n_o  = 1'b0;
        bus.cpu_ce_o     = 1'b0;
        bus.dump_valid_o = 1'b0;
        bus.dump_data_o  = '0;
        busy_o           = 1'b0;
        done_o           = 1'b0;
        case (state_q)
            ST_LOAD: begin
                busy_o        = 1'b1;
                bus.ld_ready_o = 1'b1;
                bus.imem_we_o  = bus.ld_valid_i;
            end
            ST_RUN: begin
                busy_o          = 1'b1;
                bus.cpu_rst_n_o = 1'b1;
                bus.cpu_ce_o    = 1'b1;
            end
            ST_DUMP: begin
                busy_o           = 1'b1;
                bus.cpu_rst_n_o  = 1'b1;
                bus.dump_valid_o = 1'b1;
                bus.dump_data_o  = bus.rf_rd_data_i;
            end
            ST_DONE: begin
                done_o          = 1'b1;
                bus.cpu_rst_n_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.imem_addr_o  = waddr_q;
    assign bus.imem_wdata_o = bus.ld_data_i;
    assign bus.rf_rd_addr_o = idx_q;
    assign bus.dump_idx_o   = idx_q;
    assign load_cnt_o       = load_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam logic [31:0] RST_BASE = 32'h5A00_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] cycles_i;
    logic        busy_o, done_o;
    logic [7:0]  load_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_run_ctrl_if #(.IMEM_AW(7), .RF_AW(5)) bus ();

    cpu_run_ctrl #(.IMEM_AW(7), .CNT_W(16), .RF_AW(5)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .cycles_i   (cycles_i),
        .bus        (bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .load_cnt_o (load_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Minimal CPU stand-in: reset loads RST_BASE+i, each enabled cycle bumps r1.
    logic [31:0] rf [32];
    always @(posedge clk_i) begin
        if (!bus.cpu_rst_n_o) begin
            for (int i = 0; i < 32; i++) rf[i] <= RST_BASE + 32'(i);
        end else if (bus.cpu_ce_o) begin
            rf[1] <= rf[1] + 32'd1;
        end
    end
    assign bus.rf_rd_data_i = rf[bus.rf_rd_addr_o];

    // Observers
    logic [6:0]  wa_log [$];
    logic [31:0] wd_log [$];
    int ce_total   = 0;
    int bad_we     = 0;
    int excl_err   = 0;
    always @(posedge clk_i) begin
        if (bus.imem_we_o) begin
            wa_log.push_back(bus.imem_addr_o);
            wd_log.push_back(bus.imem_wdata_o);
            if (!(bus.ld_valid_i && bus.ld_ready_o)) bad_we <= bad_we + 1;
        end
        if (bus.cpu_ce_o) ce_total <= ce_total + 1;
    end
    always @(negedge clk_i) if (busy_o && done_o) excl_err <= excl_err + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start_i  = 1'b1;
        cycles_i = n;
        tick();
        start_i  = 1'b0;
        cycles_i = 16'h0007;   // changes after sampling; must not affect the run
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input int gap);
        int g = 0;
        if (gap > 0) begin
            bus.ld_valid_i = 1'b0;
            repeat (gap) begin
                tick();
                check("ld_gap_no_we", bus.imem_we_o, 1'b0);
            end
        end
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = d;
        bus.ld_last_i  = last;
        #1;
        while (!bus.ld_ready_o && g < 100) begin
            tick();
            g++;
        end
        check("ld_ready_wait", bus.ld_ready_o, 1'b1);
        tick();
        bus.ld_valid_i = 1'b0;
        bus.ld_last_i  = 1'b0;
    endtask

    task automatic do_dump(input int n_run, input int stall_idx, input int stall_len);
        logic [31:0] exp;
        int g;
        bus.dump_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            g = 0;
            while (!bus.dump_valid_o && g < 200) begin
                tick();
                g++;
            end
            exp = RST_BASE + 32'(i) + ((i == 1) ? 32'(n_run) : 32'd0);
            check("dump_valid", bus.dump_valid_o, 1'b1);
            check("dump_idx", bus.dump_idx_o, 64'(i));
            check("dump_data", bus.dump_data_o, exp);
            if (i == stall_idx) begin
                bus.dump_ready_i = 1'b0;
                repeat (stall_len) begin
                    tick();
                    check("stall_idx", bus.dump_idx_o, 64'(i));
                    check("stall_data", bus.dump_data_o, exp);
                    check("stall_valid", bus.dump_valid_o, 1'b1);
                end
                bus.dump_ready_i = 1'b1;
            end
            tick();
        end
        check("done_after_dump", done_o, 1'b1);
        check("busy_after_dump", busy_o, 1'b0);
        check("done_cpu_frozen", {bus.cpu_rst_n_o, bus.cpu_ce_o}, 2'b10);
        bus.dump_ready_i = 1'b0;
    endtask

    initial begin
        int base, ce0, err;
        rst_i            = 1'b1;
        start_i          = 1'b0;
        cycles_i         = '0;
        bus.ld_valid_i   = 1'b0;
        bus.ld_data_i    = '0;
        bus.ld_last_i    = 1'b0;
        bus.dump_ready_i = 1'b0;
        #2;
        // Reset state
        check("rst_cpu_rst_n", bus.cpu_rst_n_o, 1'b0);
        check("rst_cpu_ce", bus.cpu_ce_o, 1'b0);
        check("rst_ld_ready", bus.ld_ready_o, 1'b0);
        check("rst_imem_we", bus.imem_we_o, 1'b0);
        check("rst_dump_valid", bus.dump_valid_o, 1'b0);
        check("rst_busy_done", {busy_o, done_o}, 2'b00);
        check("rst_load_cnt", load_cnt_o, 8'd0);
        check("rst_idx", bus.dump_idx_o, 5'd0);
        repeat (2) tick();
        rst_i = 1'b0;
        tick();

        // Basic run: 3 words, 5 cycles
        do_start(16'd5);
        check("b_load_busy", busy_o, 1'b1);
        check("b_load_ready", bus.ld_ready_o, 1'b1);
        check("b_load_cpu_rst", bus.cpu_rst_n_o, 1'b0);
        base = wa_log.size();
        ce0  = ce_total;
        for (int i = 0; i < 3; i++) send_word(32'h1111_0000 + 32'(i), i == 2, 0);
        check("b_wr_count", 64'(wa_log.size() - base), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("b_wr_addr", wa_log[base + i], 64'(i));
            check("b_wr_data", wd_log[base + i], 32'h1111_0000 + 32'(i));
        end
        check("b_load_cnt", load_cnt_o, 8'd3);
        check("b_run_cpu", {bus.cpu_rst_n_o, bus.cpu_ce_o}, 2'b11);
        repeat (4) tick();
        check("b_ce_4th", bus.cpu_ce_o, 1'b1);
        tick();
        check("b_ce_off", bus.cpu_ce_o, 1'b0);
        check("b_dump_valid", bus.dump_valid_o, 1'b1);
        check("b_ce_total", 64'(ce_total - ce0), 64'd5);
        do_dump(5, -1, 0);

        // Restart from DONE: 2 cycles, gapped load, dump stall at idx 7
        tick();
        do_start(16'd2);
        check("r_cpu_rst", bus.cpu_rst_n_o, 1'b0);
        check("r_load_cnt_clr", load_cnt_o, 8'd0);
        check("r_busy_done", {busy_o, done_o}, 2'b10);
        base = wa_log.size();
        ce0  = ce_total;
        send_word(32'hAAAA_0001, 1'b0, 2);
        send_word(32'hAAAA_0002, 1'b1, 3);
        check("r_wr_count", 64'(wa_log.size() - base), 64'd2);
        check("r_wr_addr0", wa_log[base], 7'd0);
        check("r_wr_addr1", wa_log[base + 1], 7'd1);
        check("r_wr_data1", wd_log[base + 1], 32'hAAAA_0002);
        check("r_load_cnt", load_cnt_o, 8'd2);
        repeat (2) tick();
        check("r_dump_valid", bus.dump_valid_o, 1'b1);
        check("r_ce_total", 64'(ce_total - ce0), 64'd2);
        do_dump(2, 7, 4);

        // Memory full: 128 words, never ld_last_i
        do_start(16'd3);
        base = wa_log.size();
        bus.ld_valid_i = 1'b1;
        bus.ld_last_i  = 1'b0;
        for (int i = 0; i < 128; i++) begin
            bus.ld_data_i = 32'hC000_0000 + 32'(i);
            tick();
        end
        bus.ld_valid_i = 1'b0;
        check("f_wr_count", 64'(wa_log.size() - base), 64'd128);
        err = 0;
        for (int i = 0; i < 128; i++) begin
            if (wa_log[base + i] !== 7'(i) || wd_log[base + i] !== 32'hC000_0000 + 32'(i)) err++;
        end
        check("f_wr_seq_errs", 64'(err), 64'd0);
        check("f_last_addr", wa_log[base + 127], 7'd127);
        check("f_load_cnt", load_cnt_o, 8'd128);
        check("f_in_run", {bus.cpu_ce_o, bus.ld_ready_o}, 2'b10);
        do_dump(3, -1, 0);

        // Zero-cycle run
        ce0 = ce_total;
        do_start(16'd0);
        send_word(32'hDEAD_BEEF, 1'b1, 0);
        check("z_dump_direct", bus.dump_valid_o, 1'b1);
        check("z_ce_low", bus.cpu_ce_o, 1'b0);
        check("z_load_cnt", load_cnt_o, 8'd1);
        do_dump(0, -1, 0);
        check("z_ce_never", 64'(ce_total - ce0), 64'd0);

        // Async reset mid-RUN, with ignored start/ld_valid during RUN
        do_start(16'd10);
        send_word(32'h0BAD_F00D, 1'b1, 0);
        base = wa_log.size();
        start_i        = 1'b1;
        bus.ld_valid_i = 1'b1;
        bus.ld_last_i  = 1'b1;
        #1;
        check("a_ld_ready_run", bus.ld_ready_o, 1'b0);
        check("a_we_run", bus.imem_we_o, 1'b0);
        tick();
        start_i        = 1'b0;
        bus.ld_valid_i = 1'b0;
        bus.ld_last_i  = 1'b0;
        check("a_start_ignored", {bus.cpu_rst_n_o, bus.cpu_ce_o, busy_o}, 3'b111);
        check("a_no_write", 64'(wa_log.size() - base), 64'd0);
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        check("a_rst_cpu", {bus.cpu_rst_n_o, bus.cpu_ce_o}, 2'b00);
        check("a_rst_busy_done", {busy_o, done_o}, 2'b00);
        check("a_rst_dump", bus.dump_valid_o, 1'b0);
        check("a_rst_load_cnt", load_cnt_o, 8'd0);
        repeat (2) tick();
        rst_i = 1'b0;
        bus.dump_ready_i = 1'b1;
        repeat (3) tick();
        check("a_idle_after", {busy_o, done_o, bus.ld_ready_o, bus.dump_valid_o, bus.cpu_rst_n_o}, 5'b00000);

        check("we_only_on_handshake", 64'(bad_we), 64'd0);
        check("busy_done_exclusive", 64'(excl_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
